// File: rtl/avalon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_pkg
//  Description : Shared types and constants for the Avalon-MM PIO initiator
//                family: FSM state encoding, idle strobe levels and the
//                read-latency counter width.
//  Contents    : avm_state_t      - IDLE / ACCESS / LATENCY / RESP
//                IDLE_*           - strobe levels driven when no access runs
//                lat_cnt_width()  - bits needed for a 0..7 latency count
//  Revision    : 1.0 - initial release
// ============================================================================
package avalon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_LATENCY = 2'd2,
    ST_RESP    = 2'd3
  } avm_state_t;

  // Bus strobe levels while no access is in progress.
  localparam logic IDLE_CHIPSELECT = 1'b0;
  localparam logic IDLE_READ       = 1'b0;
  localparam logic IDLE_WRITE_N    = 1'b1;

  localparam int MAX_READ_LATENCY = 7;

  function automatic int lat_cnt_width();
    return $clog2(MAX_READ_LATENCY + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/avm_stall_timer.sv
`default_nettype none
// ============================================================================
//  Module      : avm_stall_timer
//  Description : Saturating stall counter with expiry flag for Avalon-MM
//                initiators. Counts cycles in which 'stall' is high, stops at
//                MAX, and raises 'expired' once the count equals MAX.
//                MAX = 0 disables expiry entirely.
//  Ports       : clk     in  clock
//                reset   in  synchronous active-high reset
//                clear   in  restart the count from zero
//                stall   in  count this cycle
//                expired out count has reached MAX
//  Revision    : 1.0 - initial release
// ============================================================================
module avm_stall_timer #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam int CNT_W = (MAX > 0) ? $clog2(MAX + 1) : 1;

  generate
    if (MAX == 0) begin : g_never
      logic unused_inputs;
      assign unused_inputs = ^{clk, reset, clear, stall};
      assign expired       = 1'b0;
    end else begin : g_count
      localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX);
      logic [CNT_W-1:0] count;

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          count <= '0;
        end else if (stall && (count != LIMIT)) begin
          count <= count + CNT_W'(1);
        end
      end

      assign expired = (count == LIMIT);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/avalon_pio_master.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_pio_master
//  Description : Avalon-MM initiator that executes single-beat commands from a
//                valid/ready queue as read or write cycles on a PIO-style
//                slave (registered readdata, active-low write strobe). One
//                command outstanding at most; stalled accesses are aborted
//                after TIMEOUT waitrequest cycles (0 = never).
//  Ports       : clk, reset                       clock, sync active-high reset
//                cmd_valid/ready/write/address/writedata   command queue
//                rsp_valid/ready/readdata/error            response queue
//                avm_address/chipselect/read/write_n/writedata  bus outputs
//                avm_waitrequest/readdata                       bus inputs
//  Revision    : 1.0 - initial release
// ============================================================================
module avalon_pio_master
  import avalon_pkg::*;
#(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_writedata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_readdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_read,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata
);

  localparam int LAT_W = lat_cnt_width();
  localparam logic [LAT_W-1:0] LAT_LOAD =
    LAT_W'((READ_LATENCY > 0) ? (READ_LATENCY - 1) : 0);

  avm_state_t       state;
  avm_state_t       state_nxt;
  logic             wr_q;
  logic [LAT_W-1:0] lat_cnt;

  logic accept;
  logic stall;
  logic expired;
  logic abort;
  logic wr_done;
  logic capture;
  logic lat_load;

  avm_stall_timer #(
    .MAX (TIMEOUT)
  ) u_stall_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .stall   (stall),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    avm_chipselect = IDLE_CHIPSELECT;
    avm_read       = IDLE_READ;
    avm_write_n    = IDLE_WRITE_N;
    accept         = 1'b0;
    stall          = 1'b0;
    abort          = 1'b0;
    wr_done        = 1'b0;
    capture        = 1'b0;
    lat_load       = 1'b0;

    case (state)
      ST_IDLE: begin
        // Gated by reset so nothing is offered while reset is held.
        cmd_ready = !reset;
        if (cmd_valid && !reset) begin
          accept    = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (expired) begin
          // Strobes drop in the expiry cycle so the slave never sees a
          // transfer complete on an aborted command.
          abort     = 1'b1;
          state_nxt = ST_RESP;
        end else begin
          avm_chipselect = 1'b1;
          avm_read       = !wr_q;
          avm_write_n    = !wr_q;
          if (avm_waitrequest) begin
            stall = 1'b1;
          end else if (wr_q) begin
            wr_done   = 1'b1;
            state_nxt = ST_RESP;
          end else if (READ_LATENCY == 0) begin
            capture   = 1'b1;
            state_nxt = ST_RESP;
          end else begin
            lat_load  = 1'b1;
            state_nxt = ST_LATENCY;
          end
        end
      end

      ST_LATENCY: begin
        if (lat_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = ST_RESP;
        end
      end

      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address/data hold their last value between accesses; only the strobes
  // return to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      avm_address   <= '0;
      avm_writedata <= '0;
      wr_q          <= 1'b0;
      lat_cnt       <= '0;
      rsp_readdata  <= '0;
      rsp_error     <= 1'b0;
    end else begin
      if (accept) begin
        avm_address <= cmd_address;
        wr_q        <= cmd_write;
        if (cmd_write) begin
          avm_writedata <= cmd_writedata;
        end
      end

      if (lat_load) begin
        lat_cnt <= LAT_LOAD;
      end else if ((state == ST_LATENCY) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end

      if (capture) begin
        rsp_readdata <= avm_readdata;
        rsp_error    <= 1'b0;
      end else if (wr_done) begin
        rsp_readdata <= '0;
        rsp_error    <= 1'b0;
      end else if (abort) begin
        rsp_readdata <= '0;
        rsp_error    <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avalon_pio_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avalon_pio_master
//  Description : Self-checking bench for avalon_pio_master (READ_LATENCY=1,
//                TIMEOUT=4) against a small PIO slave model with registered
//                readdata and a bench-controlled waitrequest.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_pio_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [1:0]  cmd_address = 2'd0;
  logic [31:0] cmd_writedata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_readdata;
  logic        rsp_error;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_read;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata;

  always #5 clk = ~clk;

  avalon_pio_master #(
    .ADDR_W       (2),
    .DATA_W       (32),
    .READ_LATENCY (1),
    .TIMEOUT      (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_address     (cmd_address),
    .cmd_writedata   (cmd_writedata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_readdata    (rsp_readdata),
    .rsp_error       (rsp_error),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_read        (avm_read),
    .avm_write_n     (avm_write_n),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata)
  );

  // PIO slave model: address 0 is the data register, other addresses read 0.
  logic [31:0] in_port  = 32'h0;
  logic [31:0] out_port = 32'h0;
  logic [31:0] pio_rd   = 32'h0;
  int n_writes = 0, n_wr_strobe = 0, n_rd_strobe = 0, n_cs = 0;

  always @(posedge clk) begin
    pio_rd <= (avm_chipselect && avm_read && avm_address == 2'd0) ? in_port : 32'h0;
    if (avm_chipselect && !avm_write_n && !avm_waitrequest) begin
      if (avm_address == 2'd0) out_port <= avm_writedata;
      n_writes <= n_writes + 1;
    end
    if (avm_chipselect && !avm_write_n) n_wr_strobe <= n_wr_strobe + 1;
    if (avm_chipselect && avm_read)     n_rd_strobe <= n_rd_strobe + 1;
    if (avm_chipselect)                 n_cs <= n_cs + 1;
  end
  assign avm_readdata = pio_rd;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic wr, input logic [1:0] a, input logic [31:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_address = a; cmd_writedata = d;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Returns at the negedge where rsp_valid is seen; lat counts cycles from accept.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_arrives", 32'(rsp_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_readdata"}, rsp_readdata, 32'h0);
    chk({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
    chk({tag, "_chipselect"}, 32'(avm_chipselect), 32'd0);
    chk({tag, "_read"}, 32'(avm_read), 32'd0);
    chk({tag, "_write_n"}, 32'(avm_write_n), 32'd1);
    chk({tag, "_address"}, 32'(avm_address), 32'd0);
    chk({tag, "_writedata"}, avm_writedata, 32'h0);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] in_val;
    logic [31:0] exp_rd;
    int          exp_lat;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vt [7];

  initial begin
    int lat;
    int base;
    logic [31:0] held;

    // write: response 2 cycles after accept; read (latency 1): 3 cycles.
    vt[0] = '{1'b1, 2'd0, 32'hA5A5_0001, 32'h0,         32'h0,         2, 32'hA5A5_0001};
    vt[1] = '{1'b0, 2'd0, 32'h0,         32'h1234_5678, 32'h1234_5678, 3, 32'hA5A5_0001};
    vt[2] = '{1'b0, 2'd1, 32'h0,         32'h1234_5678, 32'h0,         3, 32'hA5A5_0001};
    vt[3] = '{1'b1, 2'd1, 32'h1111_2222, 32'h0,         32'h0,         2, 32'hA5A5_0001};
    vt[4] = '{1'b1, 2'd0, 32'h0000_FFFF, 32'h0,         32'h0,         2, 32'h0000_FFFF};
    vt[5] = '{1'b0, 2'd0, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 3, 32'h0000_FFFF};
    vt[6] = '{1'b0, 2'd3, 32'h0,         32'hCAFE_0000, 32'h0,         3, 32'h0000_FFFF};

    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // Table-driven single commands.
    for (int i = 0; i < 7; i++) begin
      int wr0, rd0;
      in_port = vt[i].in_val;
      wr0 = n_wr_strobe;
      rd0 = n_rd_strobe;
      issue(vt[i].wr, vt[i].addr, vt[i].wdata);
      wait_rsp(lat);
      chk($sformatf("v%0d_rdata", i), rsp_readdata, vt[i].exp_rd);
      chk($sformatf("v%0d_error", i), 32'(rsp_error), 32'd0);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
      @(negedge clk);
      chk($sformatf("v%0d_out_port", i), out_port, vt[i].exp_out);
      chk($sformatf("v%0d_wr_strobes", i), 32'(n_wr_strobe - wr0), vt[i].wr ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_rd_strobes", i), 32'(n_rd_strobe - rd0), vt[i].wr ? 32'd0 : 32'd1);
    end

    // Write stalled 3 cycles: strobes/address stable for 4 cycles, one write.
    base = n_writes;
    avm_waitrequest = 1'b1;
    issue(1'b1, 2'd0, 32'hC0DE_0003);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("stall_cs_%0d", i), 32'(avm_chipselect), 32'd1);
      chk($sformatf("stall_write_n_%0d", i), 32'(avm_write_n), 32'd0);
      chk($sformatf("stall_addr_%0d", i), 32'(avm_address), 32'd0);
      chk($sformatf("stall_wdata_%0d", i), avm_writedata, 32'hC0DE_0003);
      if (i == 4) avm_waitrequest = 1'b0;
      @(negedge clk);
    end
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("stall_rsp_error", 32'(rsp_error), 32'd0);
    chk("stall_write_count", 32'(n_writes - base), 32'd1);
    chk("stall_out_port", out_port, 32'hC0DE_0003);
    @(negedge clk);

    // Waitrequest stuck: abort after 4 stall cycles.
    base = n_rd_strobe;
    in_port = 32'h9999_9999;
    avm_waitrequest = 1'b1;
    issue(1'b0, 2'd0, 32'h0);
    wait_rsp(lat);
    chk("abort_error", 32'(rsp_error), 32'd1);
    chk("abort_rdata", rsp_readdata, 32'h0);
    chk("abort_latency", 32'(lat), 32'd6);
    chk("abort_rd_strobes", 32'(n_rd_strobe - base), 32'd4);
    avm_waitrequest = 1'b0;
    @(negedge clk);
    in_port = 32'h0F0F_1234;
    issue(1'b0, 2'd0, 32'h0);
    wait_rsp(lat);
    chk("post_abort_rdata", rsp_readdata, 32'h0F0F_1234);
    chk("post_abort_error", 32'(rsp_error), 32'd0);
    chk("post_abort_latency", 32'(lat), 32'd3);
    @(negedge clk);

    // Response back-pressure for 10 cycles with a second command waiting.
    rsp_ready = 1'b0;
    in_port = 32'h0BAD_F00D;
    issue(1'b0, 2'd0, 32'h0);
    wait_rsp(lat);
    held = rsp_readdata;
    chk("bp_rdata", held, 32'h0BAD_F00D);
    base = n_cs;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd0; cmd_writedata = 32'h5555_AAAA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_data_%0d", i), rsp_readdata, 32'h0BAD_F00D);
      chk($sformatf("bp_cmd_ready_%0d", i), 32'(cmd_ready), 32'd0);
    end
    chk("bp_no_bus_activity", 32'(n_cs - base), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released_valid", 32'(rsp_valid), 32'd0);
    chk("bp_released_ready", 32'(cmd_ready), 32'd1);
    issue(1'b1, 2'd0, 32'h5555_AAAA);
    wait_rsp(lat);
    chk("bp_next_latency", 32'(lat), 32'd2);
    @(negedge clk);
    chk("bp_next_out_port", out_port, 32'h5555_AAAA);

    // Reset during LATENCY.
    in_port = 32'h1357_2468;
    issue(1'b0, 2'd1, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_lat");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst_lat_no_rsp_%0d", i), 32'(rsp_valid), 32'd0);
    end

    // Reset during RESP.
    rsp_ready = 1'b0;
    issue(1'b1, 2'd2, 32'h0000_0077);
    wait_rsp(lat);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_resp");
    reset = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_resp_no_rsp", 32'(rsp_valid), 32'd0);

    // Fresh read after reset.
    in_port = 32'h2468_ACE0;
    issue(1'b0, 2'd0, 32'h0);
    wait_rsp(lat);
    chk("fresh_rdata", rsp_readdata, 32'h2468_ACE0);
    chk("fresh_latency", 32'(lat), 32'd3);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
